// File: rtl/adder_pkg.sv
// Shared widths and types for the registered 8-bit adder and its nibble sub-adders.
package adder_pkg;

  localparam int NIBBLE_W = 4;
  localparam int DATA_W   = 8;

  typedef logic [NIBBLE_W-1:0] nibble_t;
  typedef logic [DATA_W-1:0]   byte_t;

endpackage

// File: rtl/adder_4bit.sv
// Purely combinational 4-bit ripple-carry adder built from four full-adder stages.
module adder_4bit
  import adder_pkg::*;
(
  input  nibble_t a_i,
  input  nibble_t b_i,
  input  logic    c_i,
  output nibble_t sum_o,
  output logic    c_o
);

  logic [NIBBLE_W:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : gBit
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o = carry[NIBBLE_W];

endmodule

// File: rtl/adder_8bit.sv
// Registered 8-bit adder with carry-in/out, split into two chained nibble adders,
// with an optional register on the nibble carry boundary (PIPE_STAGE = 1).
module adder_8bit
  import adder_pkg::*;
#(
  parameter int PIPE_STAGE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] sum,
  output logic              c_out
);

  nibble_t lowSum;
  logic    c4;
  nibble_t hiA;
  nibble_t hiB;
  logic    hiCin;
  nibble_t loSumSel;
  logic    validSel;
  nibble_t hiSum;
  logic    hiCout;

  adder_4bit uLow (
    .a_i  (a[NIBBLE_W-1:0]),
    .b_i  (b[NIBBLE_W-1:0]),
    .c_i  (c_in),
    .sum_o(lowSum),
    .c_o  (c4)
  );

  if (PIPE_STAGE != 0) begin : gPipe
    // Stage 1 captures the finished low nibble plus the raw high operands.
    nibble_t lowSum_q;
    nibble_t hiA_q;
    nibble_t hiB_q;
    logic    c4_q;
    logic    valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lowSum_q <= '0;
        hiA_q    <= '0;
        hiB_q    <= '0;
        c4_q     <= 1'b0;
        valid_q  <= 1'b0;
      end else begin
        lowSum_q <= lowSum;
        hiA_q    <= a[DATA_W-1:NIBBLE_W];
        hiB_q    <= b[DATA_W-1:NIBBLE_W];
        c4_q     <= c4;
        valid_q  <= in_valid;
      end
    end

    assign hiA      = hiA_q;
    assign hiB      = hiB_q;
    assign hiCin    = c4_q;
    assign loSumSel = lowSum_q;
    assign validSel = valid_q;
  end else begin : gDirect
    assign hiA      = a[DATA_W-1:NIBBLE_W];
    assign hiB      = b[DATA_W-1:NIBBLE_W];
    assign hiCin    = c4;
    assign loSumSel = lowSum;
    assign validSel = in_valid;
  end

  adder_4bit uHigh (
    .a_i  (hiA),
    .b_i  (hiB),
    .c_i  (hiCin),
    .sum_o(hiSum),
    .c_o  (hiCout)
  );

  byte_t sum_d;
  byte_t sum_q;
  logic  cOut_d;
  logic  cOut_q;
  logic  valid_d;
  logic  valid_q;

  always_comb begin
    sum_d   = {hiSum, loSumSel};
    cOut_d  = hiCout;
    valid_d = validSel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cOut_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cOut_q  <= cOut_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign c_out     = cOut_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_adder_8bit.sv
// Self-checking bench for adder_8bit, driving one instance of each PIPE_STAGE
// setting from the same stimulus.
module tb_adder_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;

  logic       ov0, co0, ov1, co1;
  logic [7:0] s0, s1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_8bit #(.PIPE_STAGE(0)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .out_valid(ov0),
    .sum      (s0),
    .c_out    (co0)
  );

  adder_8bit #(.PIPE_STAGE(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .out_valid(ov1),
    .sum      (s1),
    .c_out    (co1)
  );

  // Reference: plain 9-bit arithmetic, delayed by one or two edges, cleared by reset
  logic [8:0] refSum;
  logic [9:0] exp0, exp1a, exp1b;

  assign refSum = {1'b0, a} + {1'b0, b} + {8'b0, c_in};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp0  <= '0;
      exp1a <= '0;
      exp1b <= '0;
    end else begin
      exp0  <= {in_valid, refSum};
      exp1a <= {in_valid, refSum};
      exp1b <= exp1a;
    end
  end

  typedef struct packed {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vc;
    logic [8:0] res;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                               input logic vc, input logic vv);
    a        = va;
    b        = vb;
    c_in     = vc;
    in_valid = vv;
  endtask

  task automatic checkStreams(input string tag);
    checkOutput({tag, "/p0 valid"}, {31'b0, ov0}, {31'b0, exp0[9]});
    if (exp0[9]) checkOutput({tag, "/p0 result"}, {23'b0, co0, s0}, {23'b0, exp0[8:0]});
    checkOutput({tag, "/p1 valid"}, {31'b0, ov1}, {31'b0, exp1b[9]});
    if (exp1b[9]) checkOutput({tag, "/p1 result"}, {23'b0, co1, s1}, {23'b0, exp1b[8:0]});
  endtask

  initial begin
    vecs[0] = '{8'h63, 8'h1A, 1'b0, 9'h07D};
    vecs[1] = '{8'h69, 8'hB0, 1'b0, 9'h119};
    vecs[2] = '{8'h0B, 8'h7B, 1'b1, 9'h087};
    vecs[3] = '{8'h00, 8'hFF, 1'b1, 9'h100};
    vecs[4] = '{8'hFF, 8'h00, 1'b1, 9'h100};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};

    // Reset held with random traffic and a running clock
    rst_n = 1'b0;
    applyStimulus(8'($urandom), 8'($urandom), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("reset p0", {22'b0, ov0, co0, s0}, 32'h0);
      checkOutput("reset p1", {22'b0, ov1, co1, s1}, 32'h0);
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end
    rst_n = 1'b1;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);

    // Directed vectors: p0 result after one edge, p1 after two
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vc, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("dir%0d p0", i), {22'b0, ov0, co0, s0}, {22'b0, 1'b1, vecs[i].res});
      checkOutput($sformatf("dir%0d p1 early", i), {31'b0, ov1}, 32'h0);
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      @(negedge clk);
      checkOutput($sformatf("dir%0d p1", i), {22'b0, ov1, co1, s1}, {22'b0, 1'b1, vecs[i].res});
      checkOutput($sformatf("dir%0d p0 idle", i), {31'b0, ov0}, 32'h0);
    end

    // Back-to-back stream with a reset pulse in the middle
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checkStreams($sformatf("stream%0d", i));
      if (i == 6) begin
        applyStimulus(8'($urandom), 8'($urandom), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset p0", {22'b0, ov0, co0, s0}, 32'h0);
        checkOutput("async reset p1", {22'b0, ov1, co1, s1}, 32'h0);
      end else if (i == 7) begin
        rst_n = 1'b1;
        applyStimulus(vecs[i % 4].va, vecs[i % 4].vb, vecs[i % 4].vc, 1'b0);
      end else begin
        applyStimulus(vecs[i % 4].va, vecs[i % 4].vb, vecs[i % 4].vc, 1'b1);
      end
    end

    // Randomized traffic against the reference
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checkStreams("random");
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkStreams("drain");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
